// File: rtl/run_control_unit.sv
// Front-panel run control: debounces RUN/STEP/RESTART buttons, detects HLT opcodes
// and drives the clock/halt controller. Optional breakpoint support under `BREAKPOINT_EN`.
module run_control_unit #(
    parameter int unsigned           DB_CYCLES  = 16,
    parameter int unsigned           DB_W       = 5,
    parameter int unsigned           OPCODE_W   = 4,
    parameter logic [OPCODE_W-1:0]   HLT_OPCODE = 4'hF,
    parameter int unsigned           ADDR_W     = 8
) (
    input  logic                internal_clock,
    input  logic                reset_n,
    input  logic                btn_run,
    input  logic                btn_step,
    input  logic                btn_restart,
    input  logic                opcode_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ADDR_W-1:0]   pc,
`ifdef BREAKPOINT_EN
    input  logic [ADDR_W-1:0]   bp_addr,
    input  logic                bp_valid,
`endif
    output logic                controller_enable,
    output logic                halted,
    output logic                resume,
    output logic                restart,
    output logic [1:0]          run_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_STEP = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES);

    // Bit 0 = RUN, bit 1 = STEP, bit 2 = RESTART
    logic [2:0]      btn_raw;
    logic [2:0]      sync1, sync2, db_level, evt;
    logic [DB_W-1:0] db_cnt [3];

    state_t state, next_state;
    logic   skip;
    logic   run_evt, step_evt, rst_evt;
    logic   hlt_hit, bp_hit, halt_req;

    assign btn_raw  = {btn_restart, btn_step, btn_run};
    assign run_evt  = evt[0];
    assign step_evt = evt[1];
    assign rst_evt  = evt[2];

    always_ff @(posedge internal_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            evt      <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                    evt[i]      <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign hlt_hit = opcode_valid & (opcode == HLT_OPCODE) & ~skip;

`ifdef BREAKPOINT_EN
    assign bp_hit = opcode_valid & bp_valid & (pc == bp_addr) & ~skip;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign bp_hit    = 1'b0;
`endif

    assign halt_req = hlt_hit | bp_hit;

    // The fetch that follows a resume is the instruction we halted on; let it through
    always_ff @(posedge internal_clock or negedge reset_n) begin
        if (!reset_n)          skip <= 1'b0;
        else if (rst_evt)      skip <= 1'b0;
        else if (resume)       skip <= 1'b1;
        else if (opcode_valid) skip <= 1'b0;
    end

    always_ff @(posedge internal_clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state        = state;
        controller_enable = 1'b0;
        halted            = 1'b0;
        resume            = 1'b0;
        restart           = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_evt) begin
                    next_state = S_RUN;
                    restart    = 1'b1;
                end
            end
            S_RUN: begin
                controller_enable = 1'b1;
                if (halt_req || run_evt) next_state = S_HALT;
            end
            S_HALT: begin
                controller_enable = 1'b1;
                halted            = 1'b1;
                if (run_evt) begin
                    next_state = S_RUN;
                    resume     = 1'b1;
                    halted     = 1'b0;
                end else if (step_evt) begin
                    next_state = S_STEP;
                    resume     = 1'b1;
                    halted     = 1'b0;
                end
            end
            S_STEP: begin
                controller_enable = 1'b1;
                // First unskipped fetch is the single stepped instruction completing
                if (opcode_valid && !skip) next_state = S_HALT;
                else if (run_evt)          next_state = S_RUN;
            end
            default: next_state = S_IDLE;
        endcase
        if (rst_evt) begin
            next_state = S_RUN;
            restart    = 1'b1;
            resume     = 1'b0;
            halted     = 1'b0;
        end
    end

    assign run_state = state;

endmodule

// File: tb/tb_run_control_unit.sv
// Directed testbench for run_control_unit; define BREAKPOINT_EN to exercise breakpoints.
`timescale 1ns/1ps
module tb_run_control_unit;

    logic       internal_clock = 1'b0;
    logic       reset_n        = 1'b0;
    logic       btn_run        = 1'b0;
    logic       btn_step       = 1'b0;
    logic       btn_restart    = 1'b0;
    logic       opcode_valid   = 1'b0;
    logic [3:0] opcode         = '0;
    logic [7:0] pc             = '0;
`ifdef BREAKPOINT_EN
    logic [7:0] bp_addr        = '0;
    logic       bp_valid       = 1'b0;
`endif
    logic       controller_enable, halted, resume, restart;
    logic [1:0] run_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int n_res, n_rst, n_both;

    always #5 internal_clock = ~internal_clock;

    run_control_unit #(
        .DB_CYCLES (16),
        .DB_W      (5),
        .OPCODE_W  (4),
        .HLT_OPCODE(4'hF),
        .ADDR_W    (8)
    ) dut (
        .internal_clock   (internal_clock),
        .reset_n          (reset_n),
        .btn_run          (btn_run),
        .btn_step         (btn_step),
        .btn_restart      (btn_restart),
        .opcode_valid     (opcode_valid),
        .opcode           (opcode),
        .pc               (pc),
`ifdef BREAKPOINT_EN
        .bp_addr          (bp_addr),
        .bp_valid         (bp_valid),
`endif
        .controller_enable(controller_enable),
        .halted           (halted),
        .resume           (resume),
        .restart          (restart),
        .run_state        (run_state)
    );

    // Advance n clocks, sampling 1ns after each rising edge and tallying pulses
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge internal_clock);
            #1;
            if (resume)             n_res++;
            if (restart)            n_rst++;
            if (resume && restart)  n_both++;
        end
    endtask

    task automatic clear_tally();
        n_res = 0; n_rst = 0; n_both = 0;
    endtask

    task automatic fetch(input logic [3:0] op, input logic [7:0] addr);
        opcode_valid = 1'b1;
        opcode       = op;
        pc           = addr;
        run_cycles(1);
        opcode_valid = 1'b0;
    endtask

    task automatic test_reset();
        run_cycles(3);
        vec_cnt++;
        if ({controller_enable, halted, resume, restart, run_state} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {controller_enable, halted, resume, restart, run_state});
        end
        reset_n = 1'b1;
        run_cycles(2);
        vec_cnt++;
        if (run_state !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_release_state: got %b expected 00", run_state);
        end
    endtask

    task automatic test_short_press();
        clear_tally();
        btn_run = 1'b1;
        run_cycles(10);
        btn_run = 1'b0;
        run_cycles(25);
        vec_cnt++;
        if (n_rst !== 0 || run_state !== 2'b00 || controller_enable !== 1'b0) begin
            err_cnt++;
            $display("FAIL short_press: got rst=%0d state=%b en=%b expected rst=0 state=00 en=0",
                     n_rst, run_state, controller_enable);
        end
    endtask

    task automatic test_power_on_run();
        int first = 0;
        int cnt   = 0;
        btn_run = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge internal_clock);
            #1;
            if (restart) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
        btn_run = 1'b0;
        run_cycles(22);
        vec_cnt++;
        if (first !== 19) begin
            err_cnt++;
            $display("FAIL run_latency: got cycle %0d expected 19", first);
        end
        vec_cnt++;
        if (cnt !== 1) begin
            err_cnt++;
            $display("FAIL run_single_event: got %0d restart pulses expected 1", cnt);
        end
        vec_cnt++;
        if (run_state !== 2'b01 || controller_enable !== 1'b1 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL run_entered: got state=%b en=%b halted=%b expected 01/1/0",
                     run_state, controller_enable, halted);
        end
    endtask

    task automatic test_hlt();
        fetch(4'h3, 8'h01);
        vec_cnt++;
        if (run_state !== 2'b01 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL non_hlt_opcode: got state=%b halted=%b expected 01/0", run_state, halted);
        end
        fetch(4'hF, 8'h02);
        vec_cnt++;
        if (run_state !== 2'b10 || halted !== 1'b1 || controller_enable !== 1'b1) begin
            err_cnt++;
            $display("FAIL hlt_halts: got state=%b halted=%b en=%b expected 10/1/1",
                     run_state, halted, controller_enable);
        end
        fetch(4'hF, 8'h03);
        run_cycles(2);
        vec_cnt++;
        if (run_state !== 2'b10 || halted !== 1'b1) begin
            err_cnt++;
            $display("FAIL hlt_in_halt: got state=%b halted=%b expected 10/1", run_state, halted);
        end
    endtask

    task automatic test_step();
        clear_tally();
        btn_step = 1'b1;
        run_cycles(25);
        btn_step = 1'b0;
        run_cycles(22);
        vec_cnt++;
        if (n_res !== 1 || n_rst !== 0 || run_state !== 2'b11 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL step_enter: got res=%0d rst=%0d state=%b halted=%b expected 1/0/11/0",
                     n_res, n_rst, run_state, halted);
        end
        fetch(4'hF, 8'h02);
        vec_cnt++;
        if (run_state !== 2'b11) begin
            err_cnt++;
            $display("FAIL step_skip: got state=%b expected 11", run_state);
        end
        fetch(4'h3, 8'h03);
        vec_cnt++;
        if (run_state !== 2'b10 || halted !== 1'b1) begin
            err_cnt++;
            $display("FAIL step_done: got state=%b halted=%b expected 10/1", run_state, halted);
        end
    endtask

    task automatic test_run_toggle();
        clear_tally();
        btn_run = 1'b1;
        run_cycles(25);
        btn_run = 1'b0;
        run_cycles(22);
        vec_cnt++;
        if (n_res !== 1 || n_rst !== 0 || run_state !== 2'b01 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL resume_run: got res=%0d rst=%0d state=%b halted=%b expected 1/0/01/0",
                     n_res, n_rst, run_state, halted);
        end
        fetch(4'hF, 8'h04);
        vec_cnt++;
        if (run_state !== 2'b01) begin
            err_cnt++;
            $display("FAIL resume_skip: got state=%b expected 01", run_state);
        end
        fetch(4'hF, 8'h05);
        vec_cnt++;
        if (run_state !== 2'b10) begin
            err_cnt++;
            $display("FAIL hlt_after_skip: got state=%b expected 10", run_state);
        end
        btn_run = 1'b1;
        run_cycles(25);
        btn_run = 1'b0;
        run_cycles(22);
        fetch(4'h2, 8'h05);
        clear_tally();
        btn_run = 1'b1;
        run_cycles(25);
        btn_run = 1'b0;
        run_cycles(22);
        vec_cnt++;
        if (n_res !== 0 || run_state !== 2'b10 || halted !== 1'b1) begin
            err_cnt++;
            $display("FAIL run_btn_halts: got res=%0d state=%b halted=%b expected 0/10/1",
                     n_res, run_state, halted);
        end
    endtask

    task automatic test_restart_combo();
        clear_tally();
        btn_restart = 1'b1;
        btn_run     = 1'b1;
        run_cycles(25);
        btn_restart = 1'b0;
        btn_run     = 1'b0;
        run_cycles(22);
        vec_cnt++;
        if (n_rst !== 1 || n_res !== 0 || n_both !== 0) begin
            err_cnt++;
            $display("FAIL restart_pulses: got rst=%0d res=%0d both=%0d expected 1/0/0",
                     n_rst, n_res, n_both);
        end
        vec_cnt++;
        if (run_state !== 2'b01 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL restart_state: got state=%b halted=%b expected 01/0", run_state, halted);
        end
    endtask

    task automatic test_reset_midpulse();
        logic seen = 1'b0;
        fetch(4'hF, 8'h06);
        btn_run = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge internal_clock);
            #1;
            if (resume) begin
                seen    = 1'b1;
                reset_n = 1'b0;
                #1;
                vec_cnt++;
                if ({controller_enable, halted, resume, restart, run_state} !== 6'b0) begin
                    err_cnt++;
                    $display("FAIL reset_midpulse: got %b expected 000000",
                             {controller_enable, halted, resume, restart, run_state});
                end
            end
        end
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL midpulse_timeout: got no resume within 30 cycles expected one");
        end
        btn_run = 1'b0;
        #3 reset_n = 1'b1;
        run_cycles(25);
        vec_cnt++;
        if (run_state !== 2'b00) begin
            err_cnt++;
            $display("FAIL post_reset_idle: got state=%b expected 00", run_state);
        end
    endtask

    task automatic test_breakpoint();
        clear_tally();
        btn_run = 1'b1;
        run_cycles(25);
        btn_run = 1'b0;
        run_cycles(22);
`ifdef BREAKPOINT_EN
        bp_valid = 1'b1;
        bp_addr  = 8'h10;
        fetch(4'h2, 8'h10);
        vec_cnt++;
        if (run_state !== 2'b10 || halted !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_halt: got state=%b halted=%b expected 10/1", run_state, halted);
        end
        btn_run = 1'b1;
        run_cycles(25);
        btn_run = 1'b0;
        run_cycles(22);
        fetch(4'h2, 8'h10);
        vec_cnt++;
        if (run_state !== 2'b01) begin
            err_cnt++;
            $display("FAIL bp_skip: got state=%b expected 01", run_state);
        end
        fetch(4'h2, 8'h11);
        fetch(4'h2, 8'h10);
        vec_cnt++;
        if (run_state !== 2'b10) begin
            err_cnt++;
            $display("FAIL bp_rehit: got state=%b expected 10", run_state);
        end
`else
        fetch(4'h2, 8'h10);
        vec_cnt++;
        if (run_state !== 2'b01 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL no_bp_run: got state=%b halted=%b expected 01/0", run_state, halted);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_power_on_run();
        test_hlt();
        test_step();
        test_run_toggle();
        test_restart_combo();
        test_reset_midpulse();
        test_breakpoint();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
